// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory arbiter.
//   state_e        boot/run state of the arbiter
//   port_e         requester identity (fetch or loader)
//   IMEM_NOP_WORD  data returned for faulted or corrupted reads (addi x0,x0,0)
//   word_index()   byte address to word index
//   addr_fault()   misaligned or out-of-range check for a byte address
package imem_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Faults on a non-word-aligned address or a word index past the end of the RAM.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (word_index(addr) >= depth);
  endfunction

endpackage

// File: rtl/imem_sram.sv
// imem_sram: single-port synchronous RAM with a registered read port.
// Contents are never reset. A write and a read cannot happen in the same cycle.
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   1 = write wdata to addr, 0 = read addr into rdata
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  read data, valid the cycle after a read access
module imem_sram
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction RAM between the CPU fetch port (F, read-only)
// and the program loader (L, read/write). F is held off in BOOT until the loader pulses l_done;
// in RUN the two ports are served round-robin. Reads return data one cycle after the grant.
// Faulted accesses (misaligned / out of range) are granted but never touch the RAM; reads
// return NOP_WORD.
// Build option: define IMEM_PARITY_EN to store an even-parity bit with each word and report
// mismatches on par_err_o (corrupted reads return NOP_WORD). Otherwise par_err_o is 0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_req/f_addr               fetch read request and byte address
//   f_gnt/f_rvalid/f_rdata     fetch grant, read valid (grant + 1), read data
//   l_req/l_we/l_addr/l_wdata  loader request, write enable, byte address, write data
//   l_gnt/l_rvalid/l_rdata     loader grant, read valid (reads only), read data
//   l_done                     pulse: boot image complete, move to RUN
//   run_o                      1 in RUN
//   addr_err_o                 pulse the cycle after a faulted grant
//   par_err_o                  pulse with rvalid on a parity mismatch
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  input  logic        l_done,
  output logic        run_o,
  output logic        addr_err_o,
  output logic        par_err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned WIDTH = 33;
`else
  localparam int unsigned WIDTH = 32;
`endif

  state_e      state_q, state_d;
  port_e       last_q, last_d;
  logic        f_rvalid_q, l_rvalid_q, err_q;
  logic [31:0] f_rdata_q, l_rdata_q;

  logic [31:0]      sel_addr;
  logic             acc, fault, ram_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;
  logic [31:0]      rd_word;

  // Grants are combinational; F is locked out in BOOT, ties go to the port that lost last time.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (state_q == BOOT) begin
      l_gnt = l_req;
    end else if (f_req && l_req) begin
      f_gnt = (last_q == PORT_L);
      l_gnt = (last_q == PORT_F);
    end else begin
      f_gnt = f_req;
      l_gnt = l_req;
    end
  end

  always_comb begin
    last_d = last_q;
    if (f_gnt) begin
      last_d = PORT_F;
    end else if (l_gnt) begin
      last_d = PORT_L;
    end
  end

  // RUN is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && l_done) begin
      state_d = RUN;
    end
  end

  assign sel_addr = f_gnt ? f_addr : l_addr;
  assign acc      = f_gnt || l_gnt;
  assign fault    = acc && addr_fault(sel_addr, DEPTH);
  assign ram_en   = acc && !fault;
  assign ram_addr = sel_addr[AW+1:2];

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {^l_wdata, l_wdata};
  // A stored word with even parity XORs to 0 across all 33 bits.
  assign rd_word   = (err_q || (^ram_rdata)) ? NOP_WORD : ram_rdata[31:0];
  assign par_err_o = (f_rvalid_q || l_rvalid_q) && !err_q && (^ram_rdata);
`else
  assign ram_wdata = l_wdata;
  assign rd_word   = err_q ? NOP_WORD : ram_rdata;
  assign par_err_o = 1'b0;
`endif

  imem_sram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (l_gnt && l_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      last_q     <= PORT_L;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      f_rdata_q  <= 32'h0;
      l_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt && !l_we;
      err_q      <= fault;
      // Hold the last delivered word so rdata stays stable between rvalids.
      if (f_rvalid_q) begin
        f_rdata_q <= rd_word;
      end
      if (l_rvalid_q) begin
        l_rdata_q <= rd_word;
      end
    end
  end

  assign f_rvalid   = f_rvalid_q;
  assign l_rvalid   = l_rvalid_q;
  assign f_rdata    = f_rvalid_q ? rd_word : f_rdata_q;
  assign l_rdata    = l_rvalid_q ? rd_word : l_rdata_q;
  assign addr_err_o = err_q;
  assign run_o      = (state_q == RUN);

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns a single-port, synchronous-read instruction RAM and shares it between two requesters: the CPU fetch port (F) and a program-loader port (L).
- L is the debug/boot loader and can read and write; F is read-only.
- A boot state machine holds F off until L signals that the image is loaded. After that, the two ports are served with round-robin arbitration.
- Sits between the core's PC/fetch stage and the loader path; it replaces the combinational, initial-block-loaded instruction memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; word index = addr[AW+1:2] with AW = clog2(DEPTH).
- NOP_WORD, 32'h00000013, data returned for faulted reads (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid (1 cycle after f_gnt).
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid (reads only).
- l_rdata  out  32  loader read data.
- l_done  in  1  single-cycle pulse: boot image complete.
- run_o  out  1  1 in RUN state.
- addr_err_o  out  1  1-cycle pulse: granted access misaligned or out of range.
- par_err_o  out  1  1-cycle pulse, parity mismatch (see optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT, last_winner=L.
  - All gnt/rvalid/err outputs = 0; rdata registers = 0.
  - RAM contents are not reset and are retained across reset.
- States: BOOT and RUN.
  - BOOT: f_gnt=0 always; l_req is granted every cycle.
  - BOOT -> RUN on the edge where l_done=1. An L access in that same cycle completes normally.
  - RUN is left only by reset; l_done in RUN is ignored.
- Grant rules:
  - Grants are combinational, in the same cycle as the request.
  - At most one access per cycle.
  - RUN, single requester: that requester is granted.
  - RUN, both requesting: grant the port that is not last_winner. last_winner updates on every grant.
  - A request not granted must be held (req and addr stable) until granted. No queueing inside the block.
- Read latency: exactly 1 cycle.
  - rdata is registered; x_rvalid=1 in the cycle after a read grant.
  - rdata holds its value until the next rvalid on that port.
  - Writes never assert l_rvalid.
- Write: RAM[idx] <= l_wdata on the granted edge. A same-cycle read is impossible (single port).
- Fault: addr[1:0]!=0 or idx>=DEPTH.
  - The access is still granted, but the RAM is not touched; a write is dropped.
  - A read returns NOP_WORD with rvalid.
  - addr_err_o pulses in the rvalid cycle for reads, and in the cycle after the grant for writes.
- Reset mid-access: a pending rvalid is cancelled and no data is delivered.

Optional Feature:
- IMEM_PARITY_EN defined:
  - Each RAM word is 33 bits: {even parity, data}. Parity is computed on write.
  - On a read, a mismatch pulses par_err_o with rvalid; rdata is replaced by NOP_WORD.
  - Words never written read back with parity status undefined in simulation. The bench must write before it reads.
- Not defined: RAM is 32 bits wide and par_err_o is tied to 0. The port list is identical in both builds.

Decomposition:
- Package imem_pkg:
  - state enum (BOOT, RUN);
  - port-id enum (PORT_F, PORT_L);
  - NOP_WORD constant;
  - a function for word index and range check.
- One sub-module, imem_sram: single-port synchronous RAM with registered output, parameterised width and depth. Width is 33 when IMEM_PARITY_EN is defined.
- Arbitration, FSM and fault muxing stay in imem_arbiter.

Test Plan:
- Boot gating: after reset, f_req=1 with f_addr=0 -> f_gnt=0 for 20 cycles. Write L to addr 0x0 with 0x0062E233, pulse l_done -> run_o=1 next cycle; then f_gnt=1 and f_rdata=0x0062E233 one cycle later.
- Round-robin: in RUN, f_req and l_req (read) held high for 6 cycles -> grants alternate F,L,F,L,F,L, starting with F (last_winner=L at reset); each rvalid lags its grant by 1 cycle.
- Load/readback: L writes 0x00500113 to 0x14 and 0xFF718393 to 0x18, then reads both -> l_rdata equals the written values and l_rvalid is never asserted on the write cycles.
- Faults:
  - F read at 0x2 -> f_rdata=0x00000013 and addr_err_o pulse.
  - L write at byte 4*DEPTH -> addr_err_o pulse; readback of word 0 is unchanged.
- Reset mid-access: assert rst_n=0 asynchronously between an F grant and its rvalid -> f_rvalid stays 0, state=BOOT. Previously written words read back intact after reboot.
- Parity (IMEM_PARITY_EN): write 0xA5A5A5A5, force-flip one stored data bit via hierarchical deposit, read -> par_err_o=1, rdata=0x00000013. Without the macro -> par_err_o stays 0.
